// File: rtl/pe_start_srl_fifo_ctrl.sv
// Shift-register start FIFO feeding one PE start input: storage, occupancy and registered flags.
// Define PE_START_FIFO_OUTREG_EN for a registered output stage (capacity DEPTH+1).
module pe_start_srl_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH+1:0] if_num_data_valid,
    output logic [ADDR_WIDTH+1:0] if_fifo_cap
);
    localparam int CW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_cnt;
    logic                  r_full_n;
    logic [CW-1:0]         w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_mem_dout;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_pop;

    assign w_wr       = if_write & if_write_ce & r_full_n;
    assign w_addr     = (r_cnt == '0) ? '0 : ADDR_WIDTH'(r_cnt - CW'(1));
    assign w_mem_dout = r_mem[w_addr];
    assign if_full_n  = r_full_n;

    // Storage is data only: never reset, entries beyond cnt are simply ignored.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[0] <= if_din;
            for (int i = 1; i < DEPTH; i++)
                r_mem[i] <= r_mem[i-1];
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_wr && !w_pop)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (w_pop && !w_wr)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_full_n <= 1'b1;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_full_n <= (w_cnt_nxt != CW'(DEPTH));
        end
    end

`ifdef PE_START_FIFO_OUTREG_EN
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_ovld;

    // The output register refills whenever it is empty or being drained this cycle.
    assign w_rd  = if_read & if_read_ce & r_ovld;
    assign w_pop = (r_cnt != '0) & (~r_ovld | w_rd);

    always_ff @(posedge clk) begin
        if (w_pop)
            r_out <= w_mem_dout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ovld <= 1'b0;
        else if (w_pop)
            r_ovld <= 1'b1;
        else if (w_rd)
            r_ovld <= 1'b0;
    end

    assign if_dout           = r_out;
    assign if_empty_n        = r_ovld;
    assign if_num_data_valid = (ADDR_WIDTH+2)'(r_cnt) + (ADDR_WIDTH+2)'(r_ovld);
    assign if_fifo_cap       = (ADDR_WIDTH+2)'(DEPTH + 1);
`else
    logic r_empty_n;

    assign w_rd  = if_read & if_read_ce & r_empty_n;
    assign w_pop = w_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_empty_n <= 1'b0;
        else
            r_empty_n <= (w_cnt_nxt != '0);
    end

    assign if_dout           = w_mem_dout;
    assign if_empty_n        = r_empty_n;
    assign if_num_data_valid = (ADDR_WIDTH+2)'(r_cnt);
    assign if_fifo_cap       = (ADDR_WIDTH+2)'(DEPTH);
`endif

endmodule

// File: tb/tb_pe_start_srl_fifo_ctrl.sv
// Directed bench for pe_start_srl_fifo_ctrl (default build, DEPTH=2, 8-bit tokens).
module tb_pe_start_srl_fifo_ctrl;
    localparam int DW = 8;
    localparam int AW = 1;
    localparam int DP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce, if_write, if_read_ce, if_read;
    logic [DW-1:0] if_din, if_dout;
    logic          if_full_n, if_empty_n;
    logic [AW+1:0] if_num_data_valid, if_fifo_cap;

    int n_checks = 0;
    int n_fail   = 0;

    pe_start_srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
        .if_num_data_valid(if_num_data_valid), .if_fifo_cap(if_fifo_cap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic e_n, input logic f_n,
                                input int cnt, input logic [DW-1:0] d, input logic chk_d);
        check({tag, " empty_n"}, 32'(if_empty_n), 32'(e_n));
        check({tag, " full_n"},  32'(if_full_n),  32'(f_n));
        check({tag, " count"},   32'(if_num_data_valid), 32'(cnt));
        if (chk_d) check({tag, " dout"}, 32'(if_dout), 32'(d));
    endtask

    logic [DW-1:0] toks [4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};

    initial begin
        reset = 1'b1;
        if_write_ce = 1'b1; if_write = 1'b0; if_din = '0;
        if_read_ce  = 1'b1; if_read  = 1'b0;
        step(); step();
        expect_state("reset", 1'b0, 1'b1, 0, '0, 1'b0);
        check("fifo_cap", 32'(if_fifo_cap), 32'd2);
        reset = 1'b0;

        // single write, show-ahead next cycle
        if_write = 1'b1; if_din = 8'h01;
        step();
        if_write = 1'b0;
        expect_state("wr1", 1'b1, 1'b1, 1, 8'h01, 1'b1);

        // fill, then a rejected third write
        if_write = 1'b1; if_din = 8'h00;
        step();
        expect_state("wr2", 1'b1, 1'b0, 2, 8'h01, 1'b1);
        if_din = 8'h77;
        step();
        if_write = 1'b0;
        expect_state("wr3_blocked", 1'b1, 1'b0, 2, 8'h01, 1'b1);

        // drain in order
        if_read = 1'b1;
        step();
        expect_state("rd1", 1'b1, 1'b1, 1, 8'h00, 1'b1);
        step();
        if_read = 1'b0;
        expect_state("rd2", 1'b0, 1'b1, 0, '0, 1'b0);

        // streaming with read held high: one token in, one out per cycle
        if_read = 1'b1; if_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if_din = toks[k];
            step();
            expect_state($sformatf("stream%0d", k), 1'b1, 1'b1, 1, toks[k], 1'b1);
        end
        if_write = 1'b0;
        step();
        if_read = 1'b0;
        expect_state("stream_end", 1'b0, 1'b1, 0, '0, 1'b0);

        // full with simultaneous write and read: only the read goes through
        if_write = 1'b1; if_din = 8'h11;
        step();
        if_din = 8'h22;
        step();
        expect_state("fill", 1'b1, 1'b0, 2, 8'h11, 1'b1);
        if_din = 8'h33; if_read = 1'b1;
        step();
        if_write = 1'b0; if_read = 1'b0;
        expect_state("full_wr_rd", 1'b1, 1'b1, 1, 8'h22, 1'b1);

        // clock enables low: requests ignored
        if_write = 1'b1; if_write_ce = 1'b0; if_din = 8'h99;
        if_read  = 1'b1; if_read_ce  = 1'b0;
        step(); step();
        expect_state("ce_low", 1'b1, 1'b1, 1, 8'h22, 1'b1);
        if_write = 1'b0; if_read = 1'b0;
        if_write_ce = 1'b1; if_read_ce = 1'b1;

        // asynchronous reset with the FIFO full
        if_write = 1'b1; if_din = 8'h44;
        step();
        expect_state("prefill", 1'b1, 1'b0, 2, 8'h22, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        expect_state("async_rst", 1'b0, 1'b1, 0, '0, 1'b0);
        step();
        expect_state("rst_hold", 1'b0, 1'b1, 0, '0, 1'b0);
        reset = 1'b0;
        if_din = 8'h55;
        step();
        if_write = 1'b0;
        expect_state("post_rst_wr", 1'b1, 1'b1, 1, 8'h55, 1'b1);
        if_read = 1'b1;
        step();
        if_read = 1'b0;
        expect_state("post_rst_rd", 1'b0, 1'b1, 0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_start_srl_fifo_ctrl.md
# pe_start_srl_fifo_ctrl

Control logic for the shift-register start FIFOs that carry start tokens from the dataflow scheduler to each PE instance of the i4xi4 linear-layer array. It owns the shift-register storage array and its write-enable and read-address sequencing. It tracks occupancy and presents a registered full/empty handshake on both sides. Producer and consumer are single-cycle HLS-style ports; one instance sits in front of each PE start input.

## Interface
- DATA_WIDTH, 1, token width in bits
- ADDR_WIDTH, 1, read-address width; must satisfy 2^ADDR_WIDTH >= DEPTH
- DEPTH, 2, shift-register storage entries (>= 2)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_write_ce  in  1  write-side clock enable
- if_write  in  1  write request
- if_din  in  DATA_WIDTH  write data
- if_full_n  out  1  registered; 1 = space available
- if_read_ce  in  1  read-side clock enable
- if_read  in  1  read request / pop
- if_dout  out  DATA_WIDTH  oldest entry (show-ahead)
- if_empty_n  out  1  registered; 1 = if_dout valid
- if_num_data_valid  out  ADDR_WIDTH+2  current occupancy
- if_fifo_cap  out  ADDR_WIDTH+2  constant total capacity

## Operation
- Accepted write: wr = if_write & if_write_ce & if_full_n. Accepted read: rd = if_read & if_read_ce & if_empty_n.
- Storage: DEPTH-entry shift register. Every entry shifts by one on wr, with if_din entering entry 0. Read data is entry[addr].
- Counter cnt, range 0..DEPTH. It increments on wr & !rd and decrements on rd & !wr; otherwise it holds.
- addr = cnt-1, saturated at 0 when cnt = 0.
- wr & rd together with 0 < cnt < DEPTH: shift and pop in the same cycle; cnt and addr are unchanged.
- Full (cnt = DEPTH): if_full_n = 0, so writes are not accepted. A simultaneous read still drains.
- Empty (cnt = 0): if_empty_n = 0, so reads are not accepted. if_dout is don't-care.
- Flags are registered and computed from next-state cnt. if_full_n = (cnt_next != DEPTH). if_empty_n = (cnt_next != 0).
- Requests are ignored in any cycle where the matching _ce is low.
- Reset (asynchronous, any time, including mid-transfer):
  - cnt = 0, if_empty_n = 0, if_full_n = 1, if_num_data_valid = 0.
  - Storage contents are not reset; they are discarded logically.
  - No write or read is accepted while reset is high.

## Timing
- Write-to-read latency: a write accepted at edge N gives if_empty_n = 1 and valid if_dout in the cycle after edge N.
- Flag update: both flags reflect an accepted transfer one cycle after it.
- Throughput: one write and one read per cycle, sustained, when 0 < cnt < DEPTH.
- Data path: if_dout is combinational from storage plus addr (mux depth DEPTH); there is no registered output.
- if_num_data_valid equals cnt (registered). if_fifo_cap = DEPTH.

## Configuration
- PE_START_FIFO_OUTREG_EN defined:
  - Adds a one-entry output register after the storage mux; if_dout comes straight from that register.
  - if_empty_n is the output register's valid bit.
  - The register refills from storage whenever it is empty or being popped and cnt > 0.
  - Capacity becomes DEPTH+1; if_fifo_cap = DEPTH+1; if_num_data_valid = cnt + valid.
  - Write-to-read latency becomes 2 cycles.
  - Reset clears valid.
- Macro undefined: behaviour exactly as in Operation and Timing above.

## Test plan
- Reset, then single write of din=1 -> if_empty_n rises the next cycle (2 cycles with OUTREG), if_dout=1, if_num_data_valid=1.
- DEPTH=2, write 1 then 0 with no reads -> if_full_n=0 after the second write. A third write is not accepted and cnt stays at 2. Reads return 1 then 0, then if_empty_n=0.
- Streaming alternate 1/0 with if_read held high -> one token per cycle, order preserved, cnt steady at 1, no flag glitch.
- While full, assert write and read together -> only the read is accepted; cnt 2->1 and if_full_n returns to 1 next cycle.
- if_write_ce=0 or if_read_ce=0 with requests high -> no state change.
- Assert reset mid-stream with cnt=2 -> flags immediately show empty/not-full. After release, the first write is read back correctly with no stale data.
